// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_divider : 4-bit unsigned restoring divider, one quotient bit per cycle |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_cnt;
  // Partial remainder always stays below the divisor, so its fifth bit is
  // structurally zero and is not stored.
  logic [3:0] r_rem;
  logic [3:0] r_q;
  logic [3:0] r_dvs;
  logic [3:0] r_quotient;
  logic [3:0] r_remainder;
  logic       r_dbz;

  logic [4:0] w_s;
  logic [4:0] w_d;
  logic       w_fits;
  logic [3:0] w_rem_n;
  logic [3:0] w_q_n;
  logic       w_last;

  assign w_s     = {r_rem, r_q[3]};
  assign w_d     = w_s + ~{1'b0, r_dvs} + 5'd1;
  assign w_fits  = ~w_d[4];
  assign w_rem_n = w_fits ? w_d[3:0] : w_s[3:0];
  assign w_q_n   = {r_q[2:0], w_fits};
  assign w_last  = (r_cnt == 3'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (divisor != 4'd0) ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 3'd0;
      r_rem       <= 4'd0;
      r_q         <= 4'd0;
      r_dvs       <= 4'd0;
      r_quotient  <= 4'd0;
      r_remainder <= 4'd0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != 4'd0) begin
              r_dvs <= divisor;
              r_cnt <= 3'd0;
              r_rem <= 4'd0;
              r_q   <= dividend;
            end else begin
              r_quotient  <= 4'hF;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_quotient  <= w_q_n;
            r_remainder <= w_rem_n;
            r_dbz       <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seq_divider : directed + randomized checks of seq_divider vs. a model   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: cycles left until idle, plus the result to publish.
  int m_left = 0;
  int m_quot = 0, m_rem = 0, m_dbz = 0;
  int p_quot = 0, p_rem = 0;

  seq_divider u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_quot = 0; m_rem = 0; m_dbz = 0;
    end else if (m_left == 0) begin
      if (start) begin
        if (divisor != 0) begin
          m_left = 5;
          p_quot = int'(dividend) / int'(divisor);
          p_rem  = int'(dividend) % int'(divisor);
        end else begin
          m_left = 1;
          m_quot = 15; m_rem = int'(dividend); m_dbz = 1;
        end
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_quot = p_quot; m_rem = p_rem; m_dbz = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model busy", busy, (m_left > 0) ? 1 : 0);
      chk("model done", done, (m_left == 1) ? 1 : 0);
      chk("model quotient", quotient, m_quot);
      chk("model remainder", remainder, m_rem);
      chk("model div_by_zero", div_by_zero, m_dbz);
    end
  end

  task automatic run_op(input int dd, input int dv, input int eq, input int er,
                        input int edz, input int elat, input string tag);
    int lat, bcnt;
    bit seen;
    @(posedge clk); #1;
    dividend = 4'(dd); divisor = 4'(dv); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bcnt = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1'b1;
    end
    chk({tag, " done seen"}, seen, 1);
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy cycles"}, bcnt, elat);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, edz);
  endtask

  initial begin
    int dones, seen_t, last_done, dd, dv;
    bit seen;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    run_op(13, 3, 4, 1, 0, 5, "13/3");
    @(negedge clk);
    chk("13/3 hold busy", busy, 0);
    chk("13/3 hold quotient", quotient, 4);
    run_op(15, 1, 15, 0, 0, 5, "15/1");
    run_op(3, 7, 0, 3, 0, 5, "3/7");
    run_op(9, 0, 15, 9, 1, 1, "9/0");
    run_op(8, 2, 4, 0, 0, 5, "8/2");

    // Second request during CALC must be ignored.
    @(posedge clk); #1;
    dividend = 4'd12; divisor = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'd15; divisor = 4'd15; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("12/5 done count", dones, 1);
    chk("12/5 quotient", quotient, 2);
    chk("12/5 remainder", remainder, 2);

    // Reset during the second CALC cycle.
    @(posedge clk); #1;
    dividend = 4'd14; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort no done", dones, 0);
    run_op(7, 2, 3, 1, 0, 5, "7/2");

    // Exhaustive sweep with start held high.
    @(posedge clk); #1;
    dividend = 4'd0; divisor = 4'd0; start = 1'b1;
    last_done = 0;
    for (int k = 0; k < 256; k++) begin
      dd = k / 16; dv = k % 16;
      seen = 1'b0; seen_t = 0;
      while (!seen && seen_t < 12) begin
        @(negedge clk);
        seen_t++;
        if (done) seen = 1'b1;
      end
      chk("sweep done seen", seen, 1);
      if (dv != 0) begin
        chk("sweep identity", int'(quotient) * dv + int'(remainder), dd);
        chk("sweep rem<div", (int'(remainder) < dv) ? 1 : 0, 1);
        chk("sweep dbz", div_by_zero, 0);
      end else begin
        chk("sweep /0 quotient", quotient, 15);
        chk("sweep /0 remainder", remainder, dd);
        chk("sweep /0 dbz", div_by_zero, 1);
      end
      if (k > 0) chk("sweep spacing", cyc - last_done, (dv != 0) ? 6 : 2);
      last_done = cyc;
      if (k < 255) begin
        dividend = 4'((k + 1) / 16); divisor = 4'((k + 1) % 16);
      end else begin
        start = 1'b0;
      end
    end

    // Randomized traffic, including operand churn and sporadic resets.
    repeat (3000) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 3) == 0);
      dividend = 4'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 The module SHALL have port dividend, input, 4 bits: unsigned dividend; captured on an accepted start.
REQ-005 The module SHALL have port divisor, input, 4 bits: unsigned divisor; captured on an accepted start.
REQ-006 The module SHALL have port quotient, output, 4 bits: registered result; holds its value until the next completion.
REQ-007 The module SHALL have port remainder, output, 4 bits: registered result; holds its value until the next completion.
REQ-008 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The module SHALL have port div_by_zero, output, 1 bit: set at a completion whose divisor was 0; holds its value until the next completion.

Function
REQ-011 The FSM SHALL have exactly three states, IDLE, CALC and DONE, encoded in registers.
REQ-012 IDLE transitions SHALL be as follows:
- start=1 and divisor!=0: latch operands, step counter=0, partial remainder r (5 bits)=0, working quotient q=dividend; go to CALC.
- start=1 and divisor==0: go to DONE.
- start=0: stay in IDLE.
REQ-013 Each CALC cycle SHALL perform one restoring step:
- s = {r[3:0], q[3]}.
- d = s - {1'b0, divisor}, computed as s + ~{1'b0, divisor} + 1 (add/subtract form).
- d[4]==0: r=d, q={q[2:0],1}.
- d[4]==1: r=s, q={q[2:0],0}.
- Counter increments by 1.
REQ-014 On the edge performing the 4th step, the FSM SHALL go to DONE and load quotient=final q, remainder=final r[3:0], div_by_zero=0.
REQ-015 On the divisor==0 start edge, the block SHALL load quotient=4'hF, remainder=dividend, div_by_zero=1.
REQ-016 done SHALL be 1 exactly while state is DONE (one cycle), after which the FSM returns unconditionally to IDLE.
REQ-017 Latency SHALL be fixed: done is high in the 5th cycle after the accepted start edge (divisor!=0), and in the 1st cycle after it (divisor==0).
REQ-018 The block SHALL ignore start in CALC and DONE; it SHALL NOT re-latch operands or alter the operation in progress.
REQ-019 The block SHALL ignore operand input changes after acceptance.
REQ-020 A start held continuously SHALL be accepted again in the IDLE cycle after done; back-to-back throughput is 1 result per 6 cycles (divisor!=0).
REQ-021 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor!=0; all 256 operand pairs are legal.
REQ-022 The 4-bit step counter arithmetic SHALL NOT overflow; counter width is 3 bits, terminal value 3.

Reset
REQ-023 While rst_n=0, regardless of clk, the block SHALL hold: state=IDLE, quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, counter=0, r=0, q=0.
REQ-024 When rst_n asserts mid-CALC or mid-DONE, the block SHALL abort the operation immediately, produce no done pulse, and discard the partial result.
REQ-025 After rst_n deasserts, the block SHALL accept start at the first rising edge.

Verification
REQ-026 The bench SHALL check 13/3: start pulse -> busy 1 for 5 cycles, done pulse in 5th cycle, quotient=4, remainder=1, div_by_zero=0.
REQ-027 The bench SHALL check 15/1 -> quotient=15, remainder=0; and 3/7 -> quotient=0, remainder=3.
REQ-028 The bench SHALL check 9/0 -> done in 1st cycle after start, quotient=4'hF, remainder=9, div_by_zero=1; a following 8/2 -> quotient=4, remainder=0, div_by_zero=0.
REQ-029 The bench SHALL check: start 12/5, then start 15/15 pulsed during CALC -> second request ignored; result quotient=2, remainder=2, exactly one done.
REQ-030 The bench SHALL check: start 14/3, rst_n low during 2nd CALC cycle -> all outputs 0 immediately, no done; after release, 7/2 -> quotient=3, remainder=1.
REQ-031 The bench SHALL check exhaustively all 256 pairs against REQ-021 and REQ-015, with start held high, confirming 6-cycle spacing of done pulses.
